seq_det_param: RTL
==================

Name: seq_det_param

Overview:
- Parametrised, runtime-programmable serial bit-pattern detector; successor to the team's fixed-pattern FSM detectors.
- Samples one serial bit `x` per enabled clock and compares the most recent `len` bits against a programmed pattern.
- Produces a registered, Moore-style match pulse and keeps a saturating match counter.
- Supports overlapping and non-overlapping detection. Sits on the serial input side of the small-IC datapath.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (legal range 2..32).
- CNT_W, 8, width of the match counter.
- DEF_PATTERN, 8'b0001_0010, reset pattern (low DEF_LEN bits used; reset detects 10010).
- DEF_LEN, 5, reset pattern length.
- DEF_OVERLAP, 1, reset overlap mode (1 = overlapping).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  sample enable; `x` is consumed only when en=1.
- x  input  1  serial data bit.
- cfg_load  input  1  load configuration from the cfg_* inputs.
- cfg_pattern  input  MAX_LEN  pattern; bit [len-1] is received first, bit 0 is received last.
- cfg_len  input  LEN_W=$clog2(MAX_LEN+1)  pattern length.
- cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- cnt_clr  input  1  synchronous clear of match_cnt.
- match  output  1  one-cycle pulse, registered.
- match_cnt  output  CNT_W  saturating count of matches.
- cfg_err  output  1  one-cycle pulse when a cfg_load request is rejected.

Behaviour:

Reset (rst=0, asynchronous):
- pattern=DEF_PATTERN, len=DEF_LEN, overlap=DEF_OVERLAP.
- hist=0, fill=0.
- match=0, match_cnt=0, cfg_err=0.

Internal state:
- hist: MAX_LEN-bit shift register, newest bit in bit 0.
- fill: count of valid history bits, 0..len, saturates at len.

Priority at each edge: cfg_load, then en, then idle.

cfg_load=1:
- Legal cfg_len (2..MAX_LEN):
  - Latch cfg_pattern, cfg_len and cfg_overlap.
  - hist=0, fill=0, match=0; `x` is not sampled this cycle.
- Illegal cfg_len (0, 1 or >MAX_LEN):
  - Configuration, hist and fill are unchanged; `x` is not sampled.
  - cfg_err=1 for one cycle; match=0.

en=1 and cfg_load=0:
- hist_n = {hist[MAX_LEN-2:0], x}.
- fill_n = min(fill+1, len).
- hit = (fill_n == len) and (hist_n[len-1:0] == pattern[len-1:0]).
- match is registered: match <= hit. It is high in the cycle after the edge that sampled the final pattern bit, i.e. latency 1 edge.
- If hit and overlap=1: hist <= hist_n, fill <= len. The suffix is reused, so back-to-back hits are possible.
- If hit and overlap=0: hist <= hist_n, fill <= 0. A new match needs len fresh bits.
- If no hit: hist <= hist_n, fill <= fill_n.

en=0 and cfg_load=0:
- hist and fill hold.
- match=0, cfg_err=0.

match_cnt:
- On hit, increments by 1; saturates at 2^CNT_W-1 and does not wrap.
- cnt_clr=1 clears the counter. If cnt_clr and hit occur in the same cycle, the result is 1.
- cnt_clr=1 together with cfg_load leaves the counter at 0.
- cfg_load by itself does not clear the counter.

Boundary rules:
- Bits of hist above len-1 are ignored in the compare.
- Changing cfg_* inputs without cfg_load has no effect.
- rst asserted mid-sequence clears everything immediately. The first match after rst release needs the full len bits.
- A match pulse lasts exactly 1 cycle even if the next sampled bit completes another match. Consecutive overlapping hits give consecutive pulses with no gap.

Test Plan:
- Reset defaults (10010, overlap=1), en=1, x stream 1,0,0,1,0,0,1,0 -> match high after the 5th and 8th sampling edges; match_cnt=2.
- cfg_load with pattern=5'b10010, len=5, overlap=0, then the same stream -> match only after the 5th edge; match_cnt=1.
- cfg_load with len=8, pattern=8'hA5, overlap=1, stream A5A5 (MSB first) -> matches at bit 8 and bit 16; insert en=0 for 3 cycles mid-stream -> same match positions, with match low while en=0.
- cfg_load with cfg_len=0, and separately cfg_len=9 -> cfg_err pulses 1 cycle each; the previous pattern still detects 10010.
- CNT_W=2, feed 5 overlapping hits of pattern 2'b11 (len=2, stream of 1s) -> match_cnt saturates at 3; cnt_clr on a hit cycle -> match_cnt=1.
- Assert rst after 4 bits of 1001 -> match=0; the following single 0 gives no match; a full 10010 afterwards -> match.

Source files
------------

// File: rtl/seq_det_param.sv
// Runtime-programmable serial pattern detector: compares the last `len` sampled
// bits of `x` against a loaded pattern and counts matches with saturation.
module seq_det_param #(
  parameter int          MAX_LEN     = 8,
  parameter int          CNT_W       = 8,
  parameter logic [31:0] DEF_PATTERN = 32'b0001_0010,
  parameter int          DEF_LEN     = 5,
  parameter bit          DEF_OVERLAP = 1'b1,
  localparam int         LEN_W       = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               x,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cfg_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [MAX_LEN-1:0] pattern_reg;
  logic [LEN_W-1:0]   len_reg;
  logic               overlap_reg;
  logic [MAX_LEN-1:0] hist_reg;
  logic [LEN_W-1:0]   fill_reg;

  logic [MAX_LEN-1:0] hist_next;
  logic [LEN_W-1:0]   fill_next;
  logic [MAX_LEN-1:0] len_mask;
  logic               cfg_legal;
  logic               hit;
  logic [CNT_W-1:0]   cnt_next;

  // Only the low len_reg bits of the history take part in the compare.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_LEN; gi++) begin : g_mask
      localparam logic [LEN_W-1:0] BIT_IDX = LEN_W'(gi);
      assign len_mask[gi] = (BIT_IDX < len_reg);
    end
  endgenerate

  assign cfg_legal = (cfg_len >= LEN_W'(2)) && (cfg_len <= LEN_W'(MAX_LEN));
  assign hist_next = {hist_reg[MAX_LEN-2:0], x};
  assign fill_next = (fill_reg >= len_reg) ? len_reg : fill_reg + LEN_W'(1);
  assign hit       = en && !cfg_load && (fill_next == len_reg) &&
                     (((hist_next ^ pattern_reg) & len_mask) == '0);

  always_comb begin
    cnt_next = match_cnt;
    if (cnt_clr)
      cnt_next = hit ? CNT_W'(1) : '0;
    else if (hit && match_cnt != CNT_MAX)
      cnt_next = match_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pattern_reg <= DEF_PATTERN[MAX_LEN-1:0];
      len_reg     <= LEN_W'(DEF_LEN);
      overlap_reg <= DEF_OVERLAP;
      hist_reg    <= '0;
      fill_reg    <= '0;
      match       <= 1'b0;
      match_cnt   <= '0;
      cfg_err     <= 1'b0;
    end else begin
      match     <= hit;
      match_cnt <= cnt_next;
      cfg_err   <= cfg_load && !cfg_legal;
      if (cfg_load) begin
        if (cfg_legal) begin
          pattern_reg <= cfg_pattern;
          len_reg     <= cfg_len;
          overlap_reg <= cfg_overlap;
          hist_reg    <= '0;
          fill_reg    <= '0;
        end
      end else if (en) begin
        hist_reg <= hist_next;
        // Non-overlapping mode discards the matched bits so the next hit needs len fresh bits.
        if (hit)
          fill_reg <= overlap_reg ? len_reg : '0;
        else
          fill_reg <= fill_next;
      end
    end
  end

endmodule
